packet_tx: RTL
==============

Name: packet_tx

Overview:
- Framing transmitter for response packets; the other end of the executor's tx packet interface.
- Captures one parallel packet (length plus 16 byte slots) on a single write strobe.
- Serializes it as a framed byte stream onto a valid/ready byte interface that feeds the UART transmitter.
- Holds tx_busy high until the last byte of the frame has been accepted downstream.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- MAX_LEN, 16, payload byte slots; lengths above this are clamped.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- tx_packet_wr  input  1  one-cycle strobe: capture length and buffer.
- tx_payload_len  input  8  payload byte count.
- tx_buf0 .. tx_buf15  input  8 each  payload byte slots, buf0 sent first.
- tx_busy  output  1  frame in progress.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the byte when high together with out_valid.
- frame_count  output  16  frames completed, wraps 0xFFFF→0.
- drop_count  output  8  writes ignored while busy, saturates at 0xFF.

Behaviour:
- Reset values: tx_busy=0, out_valid=0, out_data=0, frame_count=0, drop_count=0; state S_IDLE.
- Reset mid-frame aborts immediately: out_valid and tx_busy are low on the next cycle and no partial bytes follow. Counters clear.
- Frame format: SYNC_BYTE, LEN, payload[0..LEN-1], CHK.
  - LEN = min(tx_payload_len, MAX_LEN).
  - CHK = XOR of LEN and all transmitted payload bytes (8-bit).
- Capture: in S_IDLE, tx_packet_wr=1 at edge T latches LEN, all 16 slots and the CHK seed. From cycle T+1: tx_busy=1, out_valid=1, out_data=SYNC_BYTE.
  - Single-cycle acceptance latency keeps tx_busy high by the time the executor first tests it (two cycles after it asserts write).
- tx_packet_wr with tx_busy=1 is ignored, increments drop_count, and does not corrupt latched data.
- States:
  - S_IDLE (out_valid=0) → S_SYNC on write.
  - S_SYNC → S_LEN on handshake.
  - S_LEN → S_DATA if LEN>0, else S_CHK, on handshake.
  - S_DATA: 4-bit index advances per handshake; after byte LEN-1 is accepted → S_CHK.
  - S_CHK → S_IDLE on handshake; frame_count increments on that edge.
- Handshake: a byte transfers on a rising edge with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - out_valid never drops mid-frame; bytes go back-to-back when out_ready stays high (one byte per cycle).
- tx_busy falls on the cycle after the CHK handshake. A new write in that same cycle is accepted. A write in the CHK-handshake cycle itself is dropped (busy still 1).
- Running checksum updates only on LEN/payload handshakes, never on stall cycles.
- Latched data is used from slot registers only; tx_buf inputs may change freely after capture.
- Minimum frame (LEN=0) is 3 bytes; maximum is 19.

Test Plan:
- Write len=3, buf=81 BA CE, out_ready=1 → stream A5 03 81 BA CE F6 on consecutive cycles; tx_busy high 6 cycles; frame_count=1.
- Write len=0 → A5 00 00; then write len=1 buf0=85 → A5 01 85 84; frame_count=2.
- len=3 (81 BA CE) with out_ready toggling 1,0,0,1,… → identical byte sequence; out_data stable during every stall; no duplicates or skips.
- Write len=20 with slots 00..0F → LEN byte 0x10, 16 payload bytes 00..0F, CHK=0x10; tx_busy low afterwards.
- Second write while busy → drop_count=1, first frame bytes unchanged; write on the first non-busy cycle → accepted, SYNC follows next cycle.
- rst pulsed during payload byte 2 → next cycle out_valid=0, tx_busy=0, counters 0; new write then produces a complete correct frame.

Source files
------------

// File: rtl/packet_tx.sv
// -----------------------------------------------------------------------------
// packet_tx
//
// Framing transmitter for response packets. A single write strobe captures a
// payload length and sixteen payload byte slots; the block then streams the
// frame
//
//     SYNC_BYTE, LEN, payload[0 .. LEN-1], CHK
//
// over a valid/ready byte interface (normally feeding a UART transmitter).
// LEN is the requested length clamped to MAX_LEN. CHK is the XOR of LEN and
// every payload byte sent.
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active high
//   tx_packet_wr    one-cycle strobe: capture length and payload slots
//   tx_payload_len  requested payload byte count (clamped to MAX_LEN)
//   tx_buf0..15     payload byte slots, tx_buf0 is sent first
//   tx_busy         high from the cycle after capture until the cycle after
//                   the checksum byte has been accepted
//   out_data        stream byte
//   out_valid       out_data is valid
//   out_ready       downstream accepts out_data when high with out_valid
//   frame_count     completed frames, wraps at 0xFFFF
//   drop_count      writes ignored because a frame was in progress,
//                   saturates at 0xFF
// -----------------------------------------------------------------------------
module packet_tx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_packet_wr,
    input  logic [7:0]  tx_payload_len,
    input  logic [7:0]  tx_buf0,
    input  logic [7:0]  tx_buf1,
    input  logic [7:0]  tx_buf2,
    input  logic [7:0]  tx_buf3,
    input  logic [7:0]  tx_buf4,
    input  logic [7:0]  tx_buf5,
    input  logic [7:0]  tx_buf6,
    input  logic [7:0]  tx_buf7,
    input  logic [7:0]  tx_buf8,
    input  logic [7:0]  tx_buf9,
    input  logic [7:0]  tx_buf10,
    input  logic [7:0]  tx_buf11,
    input  logic [7:0]  tx_buf12,
    input  logic [7:0]  tx_buf13,
    input  logic [7:0]  tx_buf14,
    input  logic [7:0]  tx_buf15,
    output logic        tx_busy,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count
);

    // The slot count is fixed by the port list; MAX_LEN only bounds LEN and
    // must not exceed it.
    localparam int         SLOTS     = 16;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CHK
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] buf_in [SLOTS];
    logic [7:0] slot_q [SLOTS];
    logic [7:0] len_q;
    logic [7:0] chk_q;
    logic [3:0] idx_q;

    logic [7:0] len_clamped;
    logic       capture;
    logic       handshake;
    logic       last_data;

    assign buf_in[0]  = tx_buf0;
    assign buf_in[1]  = tx_buf1;
    assign buf_in[2]  = tx_buf2;
    assign buf_in[3]  = tx_buf3;
    assign buf_in[4]  = tx_buf4;
    assign buf_in[5]  = tx_buf5;
    assign buf_in[6]  = tx_buf6;
    assign buf_in[7]  = tx_buf7;
    assign buf_in[8]  = tx_buf8;
    assign buf_in[9]  = tx_buf9;
    assign buf_in[10] = tx_buf10;
    assign buf_in[11] = tx_buf11;
    assign buf_in[12] = tx_buf12;
    assign buf_in[13] = tx_buf13;
    assign buf_in[14] = tx_buf14;
    assign buf_in[15] = tx_buf15;

    assign len_clamped = (tx_payload_len > MAX_LEN_B) ? MAX_LEN_B : tx_payload_len;

    // Writes are only honoured between frames; anything arriving while busy
    // is counted as a drop and leaves the latched frame untouched.
    assign capture   = (state == S_IDLE) && tx_packet_wr;
    assign handshake = out_valid && out_ready;
    assign last_data = ({4'd0, idx_q} == (len_q - 8'd1));
    assign tx_busy   = (state != S_IDLE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: state and counters use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and stream outputs
    // -------------------------------------------------------------------------
    // out_data and out_valid are decoded from registered state only, so they
    // stay stable for as long as the downstream stalls.
    // NOTE: every output of this block is given a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_data   = 8'h00;

        unique case (state)
            S_IDLE: begin
                if (tx_packet_wr) begin
                    state_next = S_SYNC;
                end
            end

            S_SYNC: begin
                out_valid = 1'b1;
                out_data  = SYNC_BYTE;
                if (out_ready) begin
                    state_next = S_LEN;
                end
            end

            S_LEN: begin
                out_valid = 1'b1;
                out_data  = len_q;
                if (out_ready) begin
                    state_next = (len_q != 8'd0) ? S_DATA : S_CHK;
                end
            end

            S_DATA: begin
                out_valid = 1'b1;
                out_data  = slot_q[idx_q];
                if (out_ready && last_data) begin
                    state_next = S_CHK;
                end
            end

            S_CHK: begin
                out_valid = 1'b1;
                out_data  = chk_q;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Payload slot storage
    // -------------------------------------------------------------------------
    // NOTE: the slot array carries no reset; it is always overwritten on
    // capture before it is read, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= buf_in[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Length, payload index and running checksum
    // -------------------------------------------------------------------------
    // The checksum is seeded with zero and folds in LEN and each payload byte
    // only on the edge where that byte is accepted, so stalls never alter it.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= 8'h00;
            chk_q <= 8'h00;
            idx_q <= 4'd0;
        end else if (capture) begin
            len_q <= len_clamped;
            chk_q <= 8'h00;
            idx_q <= 4'd0;
        end else if (handshake) begin
            if (state == S_LEN) begin
                chk_q <= chk_q ^ len_q;
            end else if (state == S_DATA) begin
                chk_q <= chk_q ^ slot_q[idx_q];
                idx_q <= idx_q + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame and drop counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= 16'h0000;
            drop_count  <= 8'h00;
        end else begin
            if (handshake && (state == S_CHK)) begin
                frame_count <= frame_count + 16'd1;
            end
            if (tx_packet_wr && tx_busy && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule
